// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and stall controller for the 5-stage
// RV32I_Zicsr core. It handles the hazards the EX forwarding path cannot
// resolve: load-use dependencies, multi-cycle data-memory accesses and
// taken-branch flushes. It also keeps a dmem wait watchdog and a stall
// performance counter.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rs1_addr_id/..    ID source operands and their use flags
//   i_rd_addr_ex/..     EX destination, write enable, load flag
//   i_mem_req_mem       MEM stage holds a load/store access
//   i_dmem_ready        data memory completes the access this cycle
//   i_branch_taken_ex   EX resolved a taken branch or jump
//   o_stall_pc          hold PC
//   o_stall_id          hold IF/ID
//   o_bubble_ex         load a NOP into ID/EX
//   o_freeze_exmem      hold ID/EX and EX/MEM; MEM/WB receives a bubble
//   o_flush_id          replace IF/ID contents with a NOP
//   o_mem_timeout       sticky: a dmem wait reached TIMEOUT cycles
//   o_stall_cycles      saturating count of cycles with o_stall_pc=1
//   dbg_state           FSM state (0 = RUN, 1 = MEM_WAIT)
//
// Control outputs are combinational from the inputs with zero latency and
// are forced low while i_rst is high. Priority: mem_wait > branch > load_use.
module hazard_ctrl #(
  parameter int XADDR   = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [XADDR-1:0] i_rs1_addr_id,
  input  logic [XADDR-1:0] i_rs2_addr_id,
  input  logic             i_rs1_used_id,
  input  logic             i_rs2_used_id,
  input  logic [XADDR-1:0] i_rd_addr_ex,
  input  logic             i_rd_wr_en_ex,
  input  logic             i_is_load_ex,
  input  logic             i_mem_req_mem,
  input  logic             i_dmem_ready,
  input  logic             i_branch_taken_ex,
  output logic             o_stall_pc,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_freeze_exmem,
  output logic             o_flush_id,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             dbg_state
);

  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  STALL_MAX = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              mem_wait;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_next;

  // Hazard conditions. x0 is hard-wired to zero, so a load to x0 never
  // produces a value the ID instruction could depend on.
  assign mem_wait = i_mem_req_mem & ~i_dmem_ready;
  assign rs1_hit  = i_rs1_used_id & (i_rs1_addr_id == i_rd_addr_ex);
  assign rs2_hit  = i_rs2_used_id & (i_rs2_addr_id == i_rd_addr_ex);
  assign load_use = i_is_load_ex & i_rd_wr_en_ex & (i_rd_addr_ex != '0) &
                    (rs1_hit | rs2_hit);

  // Next-state and control outputs.
  always_comb begin
    state_next     = state;
    o_stall_pc     = 1'b0;
    o_stall_id     = 1'b0;
    o_bubble_ex    = 1'b0;
    o_freeze_exmem = 1'b0;
    o_flush_id     = 1'b0;

    case (state)
      RUN:      if (mem_wait) state_next = MEM_WAIT;
      MEM_WAIT: if (i_dmem_ready || !i_mem_req_mem) state_next = RUN;
      default:  state_next = RUN;
    endcase

    if (!i_rst) begin
      if (mem_wait) begin
        // Whole front of the pipe holds; a branch or load-use in EX is
        // re-presented by the held EX instruction once memory is ready.
        o_stall_pc     = 1'b1;
        o_stall_id     = 1'b1;
        o_freeze_exmem = 1'b1;
      end else if (i_branch_taken_ex) begin
        // The ID instruction is discarded, so any load-use on it is moot.
        o_flush_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end else if (load_use) begin
        // One cycle is enough: next cycle the load is in MEM and EX holds
        // the bubble, so load_use drops by itself.
        o_stall_pc  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
    end
  end

  // The wait counter holds the number of completed cycles of the current
  // dmem wait. It is zero whenever the FSM sits in RUN and counts up,
  // saturating, while the wait persists (that is exactly MEM_WAIT).
  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? WAIT_MAX
                                             : wait_cnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // The watchdog only flags; the stall is never released by it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (mem_wait && (wait_cnt_next >= TIMEOUT_V)) begin
        o_mem_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
    end else if (o_stall_pc && (o_stall_cycles != STALL_MAX)) begin
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

  assign dbg_state = (state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Runs the design with a short watchdog
// (TIMEOUT=4) and a narrow stall counter (CNT_W=5) so that timeout and
// saturation are reachable quickly. Directed scenario tasks are followed by
// a randomized run checked against a behavioural model of the rules.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked on the falling edge, registered outputs 1 unit after the edge.
module tb_hazard_ctrl;

  localparam int XADDR     = 5;
  localparam int CNT_W     = 5;
  localparam int TIMEOUT   = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  // Control vector order: {stall_pc, stall_id, bubble_ex, freeze_exmem, flush_id}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_WAIT   = 5'b11010;
  localparam logic [4:0] C_BRANCH = 5'b00101;
  localparam logic [4:0] C_LOAD   = 5'b11100;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [XADDR-1:0] rs1, rs2, rd;
  logic u1, u2, wr, ld, req, rdy, br;
  logic stall_pc, stall_id, bubble_ex, freeze_exmem, flush_id, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic dbg_state;
  logic [4:0] ctrl;

  always #5 clk = ~clk;

  hazard_ctrl #(.XADDR(XADDR), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rs1_addr_id     (rs1),
    .i_rs2_addr_id     (rs2),
    .i_rs1_used_id     (u1),
    .i_rs2_used_id     (u2),
    .i_rd_addr_ex      (rd),
    .i_rd_wr_en_ex     (wr),
    .i_is_load_ex      (ld),
    .i_mem_req_mem     (req),
    .i_dmem_ready      (rdy),
    .i_branch_taken_ex (br),
    .o_stall_pc        (stall_pc),
    .o_stall_id        (stall_id),
    .o_bubble_ex       (bubble_ex),
    .o_freeze_exmem    (freeze_exmem),
    .o_flush_id        (flush_id),
    .o_mem_timeout     (mem_timeout),
    .o_stall_cycles    (stall_cycles),
    .dbg_state         (dbg_state)
  );

  assign ctrl = {stall_pc, stall_id, bubble_ex, freeze_exmem, flush_id};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_wait_len;   // cycles the current dmem wait has lasted
  int m_stall;      // stall cycles seen, clipped at STALL_MAX
  bit m_timeout;
  bit m_waiting;    // a dmem wait was in progress during the last cycle

  function automatic logic [4:0] model_ctrl();
    bit waiting, hit;
    waiting = req && !rdy;
    hit = ld && wr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst)     return C_NONE;
    if (waiting) return C_WAIT;
    if (br)      return C_BRANCH;
    if (hit)     return C_LOAD;
    return C_NONE;
  endfunction

  task automatic model_reset();
    m_wait_len = 0;
    m_stall    = 0;
    m_timeout  = 0;
    m_waiting  = 0;
  endtask

  // Advance one clock and account for what the cycle's inputs imply.
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    e = model_ctrl();
    if (e[4]) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
    m_waiting = req && !rdy;
    if (m_waiting) begin
      m_wait_len++;
      if (m_wait_len >= TIMEOUT) m_timeout = 1;
    end else begin
      m_wait_len = 0;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 0; u2 = 0; wr = 0; ld = 0; req = 0; rdy = 0; br = 0;
  endtask

  task automatic set_load_use_rs2();
    ld = 1; wr = 1; rd = 5;
    rs1 = 1; u1 = 1; rs2 = 5; u2 = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    set_load_use_rs2();
    req = 1; rdy = 0; br = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_NONE);
    end
    checks++;
    if ({mem_timeout, dbg_state, stall_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_regs got to=%b st=%b cnt=%0d want 0 0 0",
               mem_timeout, dbg_state, stall_cycles);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use_rs2();
    @(negedge clk);
    checks++;
    if (ctrl !== C_LOAD) begin
      errors++; $display("FAIL load_use_stall got %b want %b", ctrl, C_LOAD);
    end
    tick();
    // Load moved to MEM, bubble now in EX.
    ld = 0; wr = 0; rd = 0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL load_use_release got %b want %b", ctrl, C_NONE);
    end
    tick();
    checks++;
    if (stall_cycles !== CNT_W'(1)) begin
      errors++; $display("FAIL load_use_count got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    ld = 1; wr = 1; rd = 0; rs2 = 0; u2 = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL x0_no_hazard got %b want %b", ctrl, C_NONE);
    end
    tick();
    rd = 5; rs1 = 5; u1 = 0; rs2 = 3; u2 = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL unused_rs1 got %b want %b", ctrl, C_NONE);
    end
    tick();
    checks++;
    if (stall_cycles !== '0) begin
      errors++; $display("FAIL no_hazard_count got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== C_WAIT) begin
        errors++; $display("FAIL mem_wait_ctrl[%0d] got %b want %b", i, ctrl, C_WAIT);
      end
      tick();
      checks++;
      if (dbg_state !== 1'b1) begin
        errors++; $display("FAIL mem_wait_state[%0d] got %b want 1", i, dbg_state);
      end
    end
    rdy = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_NONE) begin
      errors++; $display("FAIL mem_ready_ctrl got %b want %b", ctrl, C_NONE);
    end
    tick();
    req = 0; rdy = 0;
    checks++;
    if (dbg_state !== 1'b0 || stall_cycles !== CNT_W'(3)) begin
      errors++;
      $display("FAIL mem_wait_end got st=%b cnt=%0d want 0 3", dbg_state, stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use_rs2();
    br = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_BRANCH) begin
      errors++; $display("FAIL branch_over_load got %b want %b", ctrl, C_BRANCH);
    end
    tick();
    idle_inputs();
    br = 1; req = 1; rdy = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== C_WAIT) begin
        errors++; $display("FAIL branch_in_wait[%0d] got %b want %b", i, ctrl, C_WAIT);
      end
      tick();
    end
    rdy = 1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_BRANCH) begin
      errors++; $display("FAIL branch_after_ready got %b want %b", ctrl, C_BRANCH);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1; rdy = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (mem_timeout !== (i >= TIMEOUT) || mem_timeout !== m_timeout) begin
        errors++;
        $display("FAIL timeout_flag[%0d] got %b want %b", i, mem_timeout, i >= TIMEOUT);
      end
    end
    rdy = 1;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (mem_timeout !== 1'b1 || stall_cycles !== CNT_W'(10)) begin
      errors++;
      $display("FAIL timeout_sticky got to=%b cnt=%0d want 1 10", mem_timeout, stall_cycles);
    end
    do_reset();
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b want 0", mem_timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 1; rdy = 0;
    repeat (3) tick();
    checks++;
    if (dbg_state !== 1'b1 || ctrl !== C_WAIT) begin
      errors++; $display("FAIL pre_async got st=%b ctrl=%b want 1 %b", dbg_state, ctrl, C_WAIT);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (ctrl !== C_NONE || dbg_state !== 1'b0 || stall_cycles !== '0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%b st=%b cnt=%0d to=%b want 0 0 0 0",
               ctrl, dbg_state, stall_cycles, mem_timeout);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (ctrl !== C_WAIT) begin
      errors++; $display("FAIL post_async_ctrl got %b want %b", ctrl, C_WAIT);
    end
    tick();
    rdy = 1;
    tick();
    idle_inputs();
    checks++;
    if (dbg_state !== 1'b0 || stall_cycles !== CNT_W'(1)) begin
      errors++;
      $display("FAIL post_async_resume got st=%b cnt=%0d want 0 1", dbg_state, stall_cycles);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req = 1; rdy = 0;
    for (int i = 1; i <= STALL_MAX + 4; i++) begin
      tick();
      checks++;
      if (int'(stall_cycles) !== ((i < STALL_MAX) ? i : STALL_MAX)) begin
        errors++;
        $display("FAIL stall_sat[%0d] got %0d want %0d", i, stall_cycles,
                 (i < STALL_MAX) ? i : STALL_MAX);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rs1 = XADDR'($urandom_range(0, 3));
      rs2 = XADDR'($urandom_range(0, 3));
      rd  = XADDR'($urandom_range(0, 3));
      u1  = $urandom_range(0, 1) != 0;
      u2  = $urandom_range(0, 1) != 0;
      wr  = $urandom_range(0, 3) != 0;
      ld  = $urandom_range(0, 1) != 0;
      req = $urandom_range(0, 9) < 5;
      rdy = $urandom_range(0, 9) < 4;
      br  = $urandom_range(0, 9) < 2;
      @(negedge clk);
      e = model_ctrl();
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", n, ctrl, e);
      end
      tick();
      checks++;
      if (int'(stall_cycles) !== m_stall || mem_timeout !== m_timeout ||
          dbg_state !== m_waiting) begin
        errors++;
        $display("FAIL rand_regs[%0d] got cnt=%0d to=%b st=%b want %0d %b %b",
                 n, stall_cycles, mem_timeout, dbg_state, m_stall, m_timeout, m_waiting);
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached without completing");
    $fatal(1, "time limit");
  end

endmodule
